// File: rtl/bullet_ctrl_pkg.sv
// bullet_ctrl_pkg: screen limits, slot state type and heading-to-velocity helper
package bullet_ctrl_pkg;
    localparam int SCREEN_X_MAX = 639;
    localparam int SCREEN_Y_MAX = 479;

    typedef enum logic {IDLE, FLYING} slot_state_t;

    // sign-magnitude heading component scaled by speed, as 10-bit two's complement
    function automatic logic [9:0] sm_to_vel(input logic [7:0] v, input int speed);
        logic [7:0] m;
        logic [9:0] mag;
        m = 8'((15'(speed) * 15'(v[6:0])) >> 7);
        mag = (m > 8'd15) ? 10'd15 : {2'b00, m};
        return v[7] ? -mag : mag;
    endfunction
endpackage

// File: rtl/bullet_ctrl_if.sv
// bullet_ctrl_if: tank fire interface (trigger, muzzle position, heading, spawn acknowledge)
interface bullet_ctrl_if;
    logic       shoot;
    logic [9:0] tank_x;
    logic [9:0] tank_y;
    logic [7:0] sin;
    logic [7:0] cos;
    logic       fire_ack;

    modport master (output shoot, tank_x, tank_y, sin, cos, input fire_ack);
    modport slave  (input shoot, tank_x, tank_y, sin, cos, output fire_ack);
endinterface

// File: rtl/bullet_ctrl_slot.sv
// bullet_slot: one bullet's flight FSM, position, velocity and remaining life
module bullet_slot
    import bullet_ctrl_pkg::*;
#(
    parameter int LIFETIME = 200
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       i_clear,
    input  logic       i_spawn,
    input  logic [9:0] i_spawn_x,
    input  logic [9:0] i_spawn_y,
    input  logic [9:0] i_spawn_vx,
    input  logic [9:0] i_spawn_vy,
    input  logic       i_wall_x,
    input  logic       i_wall_y,
    input  logic [9:0] i_enemy_x,
    input  logic [9:0] i_enemy_y,
    input  logic [9:0] i_enemy_s,
    output logic [9:0] o_x,
    output logic [9:0] o_y,
    output logic       o_active,
    output logic       o_hit
);
    slot_state_t       r_state, w_state_nxt;
    logic [9:0]        r_x, r_y, r_vx, r_vy;
    logic [7:0]        r_life;
    logic signed [10:0] w_dx, w_dy, w_adx, w_ady;
    logic [9:0]        w_vx, w_vy;
    logic [10:0]       w_nx, w_ny;
    logic              w_in_box, w_expired, w_off;

    assign w_dx      = $signed({1'b0, r_x}) - $signed({1'b0, i_enemy_x});
    assign w_dy      = $signed({1'b0, r_y}) - $signed({1'b0, i_enemy_y});
    assign w_adx     = w_dx[10] ? -w_dx : w_dx;
    assign w_ady     = w_dy[10] ? -w_dy : w_dy;
    assign w_in_box  = ($unsigned(w_adx) <= {1'b0, i_enemy_s}) && ($unsigned(w_ady) <= {1'b0, i_enemy_s});
    assign w_expired = r_life == 8'd0;
    assign w_vx      = i_wall_x ? -r_vx : r_vx;
    assign w_vy      = i_wall_y ? -r_vy : r_vy;
    // a negative result wraps above 1023 as unsigned, so one compare per axis catches both edges
    assign w_nx      = {1'b0, r_x} + {w_vx[9], w_vx};
    assign w_ny      = {1'b0, r_y} + {w_vy[9], w_vy};
    assign w_off     = (w_nx > 11'(SCREEN_X_MAX)) || (w_ny > 11'(SCREEN_Y_MAX));
    assign o_x       = r_x;
    assign o_y       = r_y;

    // state register
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) r_state <= IDLE;
        else if (i_clear) r_state <= IDLE;
        else r_state <= w_state_nxt;
    end

    // next state: spawn launches, hit/expiry/leaving the screen retire
    always_comb begin
        w_state_nxt = (r_state == IDLE) ? (i_spawn ? FLYING : IDLE)
                    : ((w_in_box || w_expired || w_off) ? IDLE : FLYING);
    end

    // outputs: in-flight flag and hit detect on the current position
    always_comb begin
        o_active = r_state == FLYING;
        o_hit    = (r_state == FLYING) && w_in_box;
    end

    // kinematics: load on spawn, bounce then step while flying; an off-screen step leaves position held
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {r_x, r_y, r_vx, r_vy} <= '0;
            r_life <= '0;
        end else if (i_clear) begin
            {r_x, r_y, r_vx, r_vy} <= '0;
            r_life <= '0;
        end else if (i_spawn) begin
            r_x    <= i_spawn_x;
            r_y    <= i_spawn_y;
            r_vx   <= i_spawn_vx;
            r_vy   <= i_spawn_vy;
            r_life <= 8'(LIFETIME);
        end else if (r_state == FLYING && !w_in_box && !w_expired) begin
            r_vx <= w_vx;
            r_vy <= w_vy;
            if (!w_off) begin
                r_x    <= w_nx[9:0];
                r_y    <= w_ny[9:0];
                r_life <= r_life - 8'd1;
            end
        end
    end
endmodule

// File: rtl/bullet_ctrl.sv
// bullet_ctrl: spawns bullets on fire edges and advances/retires them each frame
module bullet_ctrl
    import bullet_ctrl_pkg::*;
#(
    parameter int NUM_BULLETS  = 4,
    parameter int BULLET_SPEED = 8,
    parameter int LIFETIME     = 200,
    parameter int COOLDOWN     = 10
) (
    input  logic                      frame_clk,
    input  logic                      Reset_n,
    input  logic                      clear,
    bullet_ctrl_if.slave              fire,
    input  logic [NUM_BULLETS-1:0]    wall_x,
    input  logic [NUM_BULLETS-1:0]    wall_y,
    input  logic [9:0]                enemy_x,
    input  logic [9:0]                enemy_y,
    input  logic [9:0]                enemy_s,
    output logic [NUM_BULLETS*10-1:0] bullet_x,
    output logic [NUM_BULLETS*10-1:0] bullet_y,
    output logic [NUM_BULLETS-1:0]    bullet_active,
    output logic                      hit
);
    logic                   r_shoot_q, r_fire_ack, r_hit;
    logic [7:0]             r_cd;
    logic                   w_fire_edge, w_any_free, w_do_spawn;
    logic [2:0]             w_free_idx;
    logic [NUM_BULLETS-1:0] w_spawn, w_hit;
    logic [9:0]             w_vx, w_vy;

    assign w_fire_edge   = fire.shoot & ~r_shoot_q;
    assign w_do_spawn    = w_fire_edge && (r_cd == 8'd0) && w_any_free;
    assign w_vx          = sm_to_vel(fire.cos, BULLET_SPEED);
    assign w_vy          = -sm_to_vel(fire.sin, BULLET_SPEED);
    assign fire.fire_ack = r_fire_ack;
    assign hit           = r_hit;

    // lowest-index idle slot wins; scanning downward lets the lowest overwrite last
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!bullet_active[i]) begin
                w_any_free = 1'b1;
                w_free_idx = 3'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_BULLETS; g++) begin : g_slot
        assign w_spawn[g] = w_do_spawn && (w_free_idx == 3'(g));
        bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
            .frame_clk  (frame_clk),
            .Reset_n    (Reset_n),
            .i_clear    (clear),
            .i_spawn    (w_spawn[g]),
            .i_spawn_x  (fire.tank_x),
            .i_spawn_y  (fire.tank_y),
            .i_spawn_vx (w_vx),
            .i_spawn_vy (w_vy),
            .i_wall_x   (wall_x[g]),
            .i_wall_y   (wall_y[g]),
            .i_enemy_x  (enemy_x),
            .i_enemy_y  (enemy_y),
            .i_enemy_s  (enemy_s),
            .o_x        (bullet_x[g*10 +: 10]),
            .o_y        (bullet_y[g*10 +: 10]),
            .o_active   (bullet_active[g]),
            .o_hit      (w_hit[g])
        );
    end

    // trigger history, saturating cooldown, and registered spawn/hit pulses
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_shoot_q  <= 1'b0;
            r_cd       <= '0;
            r_fire_ack <= 1'b0;
            r_hit      <= 1'b0;
        end else if (clear) begin
            r_shoot_q  <= 1'b0;
            r_cd       <= '0;
            r_fire_ack <= 1'b0;
            r_hit      <= 1'b0;
        end else begin
            r_shoot_q  <= fire.shoot;
            r_cd       <= w_do_spawn ? 8'(COOLDOWN) : ((r_cd != 8'd0) ? r_cd - 8'd1 : 8'd0);
            r_fire_ack <= w_do_spawn;
            r_hit      <= |w_hit;
        end
    end
endmodule

// File: tb/tb_bullet_ctrl.sv
// tb_bullet_ctrl: directed scenarios plus random play against a behavioural bullet model
module tb_bullet_ctrl;
    localparam int N = 4;
    localparam int SPEED = 8;
    localparam int LIFE = 200;
    localparam int CD = 10;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    logic clear = 1'b0;
    logic [N-1:0] wall_x = '0, wall_y = '0;
    logic [9:0] enemy_x = 10'd1000, enemy_y = 10'd1000, enemy_s = 10'd0;
    logic [N*10-1:0] bullet_x, bullet_y;
    logic [N-1:0] bullet_active;
    logic hit;
    int n_chk = 0, n_fail = 0;

    bullet_ctrl_if fif();

    bullet_ctrl #(.NUM_BULLETS(N), .BULLET_SPEED(SPEED), .LIFETIME(LIFE), .COOLDOWN(CD)) dut (
        .frame_clk(clk), .Reset_n(Reset_n), .clear(clear), .fire(fif),
        .wall_x(wall_x), .wall_y(wall_y), .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_s(enemy_s),
        .bullet_x(bullet_x), .bullet_y(bullet_y), .bullet_active(bullet_active), .hit(hit)
    );

    always #5 clk = ~clk;

    int m_act[N], m_x[N], m_y[N], m_vx[N], m_vy[N], m_life[N];
    int m_cd = 0, m_sq = 0, m_ack = 0, m_hit = 0;

    function automatic int smv(input logic [7:0] v);
        int m;
        m = (SPEED * int'(v[6:0])) / 128;
        if (m > 15) m = 15;
        return v[7] ? -m : m;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // reference: one frame of game rules applied to integer bullet records
    always @(posedge clk or negedge Reset_n) begin
        if (!Reset_n || clear) begin
            for (int i = 0; i < N; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_vx[i] = 0; m_vy[i] = 0; m_life[i] = 0;
            end
            m_cd = 0; m_sq = 0; m_ack = 0; m_hit = 0;
        end else begin
            int fr, ed, sp, nx, ny, ex, ey, es;
            fr = -1;
            for (int i = N - 1; i >= 0; i--) if (m_act[i] == 0) fr = i;
            ed = (fif.shoot && m_sq == 0) ? 1 : 0;
            sp = (ed == 1 && m_cd == 0 && fr >= 0) ? 1 : 0;
            m_sq = int'(fif.shoot);
            ex = int'(enemy_x); ey = int'(enemy_y); es = int'(enemy_s);
            m_hit = 0;
            for (int i = 0; i < N; i++) begin
                if (m_act[i] == 1) begin
                    if ((m_x[i] - ex <= es) && (ex - m_x[i] <= es) && (m_y[i] - ey <= es) && (ey - m_y[i] <= es)) begin
                        m_act[i] = 0; m_hit = 1;
                    end else if (m_life[i] == 0) begin
                        m_act[i] = 0;
                    end else begin
                        if (wall_x[i]) m_vx[i] = -m_vx[i];
                        if (wall_y[i]) m_vy[i] = -m_vy[i];
                        nx = m_x[i] + m_vx[i];
                        ny = m_y[i] + m_vy[i];
                        if (nx < 0 || nx > 639 || ny < 0 || ny > 479) m_act[i] = 0;
                        else begin m_x[i] = nx; m_y[i] = ny; m_life[i]--; end
                    end
                end
            end
            if (sp == 1) begin
                m_act[fr] = 1; m_x[fr] = int'(fif.tank_x); m_y[fr] = int'(fif.tank_y);
                m_vx[fr] = smv(fif.cos); m_vy[fr] = -smv(fif.sin); m_life[fr] = LIFE;
                m_cd = CD;
            end else if (m_cd > 0) m_cd--;
            m_ack = sp;
        end
    end

    // every frame: all outputs against the model, mid-cycle
    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            chk($sformatf("active[%0d]", i), int'(bullet_active[i]), m_act[i]);
            chk($sformatf("x[%0d]", i), int'(bullet_x[i*10 +: 10]), m_x[i]);
            chk($sformatf("y[%0d]", i), int'(bullet_y[i*10 +: 10]), m_y[i]);
        end
        chk("fire_ack", int'(fif.fire_ack), m_ack);
        chk("hit", int'(hit), m_hit);
    end

    task automatic tick(input int n = 1);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic aim(input int tx, input int ty, input logic [7:0] c, input logic [7:0] s);
        fif.tank_x = 10'(tx); fif.tank_y = 10'(ty); fif.cos = c; fif.sin = s;
    endtask

    initial begin
        int cnt;
        fif.shoot = 1'b0;
        aim(0, 0, 8'h00, 8'h00);
        tick(3);
        chk("reset active", int'(bullet_active), 0);
        Reset_n = 1'b1;
        tick();

        // first shot travels right at 7 per frame
        aim(300, 250, 8'h7F, 8'h00);
        fif.shoot = 1'b1; tick();
        chk("spawn ack", int'(fif.fire_ack), 1);
        chk("spawn active0", int'(bullet_active[0]), 1);
        chk("spawn x0", int'(bullet_x[9:0]), 300);
        chk("spawn y0", int'(bullet_y[9:0]), 250);
        tick(); chk("move x 307", int'(bullet_x[9:0]), 307);
        tick(); chk("move x 314", int'(bullet_x[9:0]), 314);
        tick(); chk("move x 321", int'(bullet_x[9:0]), 321);
        chk("move y", int'(bullet_y[9:0]), 250);

        // held trigger fires once; cooldown drops an early re-press
        cnt = 0;
        for (int k = 0; k < 27; k++) begin tick(); cnt += int'(fif.fire_ack); end
        chk("held acks", cnt, 0);
        fif.shoot = 1'b0; do_clear();
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("cd spawn ack", int'(fif.fire_ack), 1);
        tick(4); fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("cd dropped", int'(fif.fire_ack), 0);
        tick(6); fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("cd later ack", int'(fif.fire_ack), 1);
        chk("cd slot1", int'(bullet_active[1]), 1);

        // vertical bounce off a wall
        do_clear();
        aim(300, 250, 8'h00, 8'h7F);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        tick(5); chk("up y 215", int'(bullet_y[9:0]), 215);
        wall_y = 4'b0001; tick(); wall_y = '0;
        chk("bounce y 222", int'(bullet_y[9:0]), 222);

        // all slots busy: fifth edge ignored
        do_clear();
        aim(100, 100, 8'h00, 8'h00);
        for (int k = 0; k < 4; k++) begin
            fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
            chk("fill ack", int'(fif.fire_ack), 1);
            tick(10);
        end
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("full no ack", int'(fif.fire_ack), 0);
        chk("full active", int'(bullet_active), 15);

        // hit on entering the enemy box
        do_clear();
        enemy_x = 10'd340; enemy_y = 10'd250; enemy_s = 10'd10;
        aim(300, 250, 8'h7F, 8'h00);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        tick(5);
        chk("hit x 335", int'(bullet_x[9:0]), 335);
        chk("no hit yet", int'(hit), 0);
        tick();
        chk("hit pulse", int'(hit), 1);
        chk("hit retire", int'(bullet_active[0]), 0);
        chk("hit x held", int'(bullet_x[9:0]), 335);
        tick(); chk("hit one cycle", int'(hit), 0);

        // two bullets converge on the box in the same frame
        do_clear();
        aim(190, 250, 8'h7F, 8'h00);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        tick(10);
        aim(413, 250, 8'hFF, 8'h00);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("second ack", int'(fif.fire_ack), 1);
        cnt = 0;
        for (int k = 0; k < 20; k++) begin tick(); cnt += int'(hit); end
        chk("dual hit pulses", cnt, 1);
        chk("dual retired", int'(bullet_active), 0);
        enemy_x = 10'd1000; enemy_y = 10'd1000; enemy_s = 10'd0;

        // lifetime: stationary bullet lasts LIFETIME moves
        do_clear();
        aim(100, 100, 8'h00, 8'h00);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        cnt = int'(bullet_active[0]);
        for (int k = 0; k < 300; k++) begin
            tick();
            if (!bullet_active[0]) break;
            cnt++;
        end
        chk("lifetime frames", cnt, 201);

        // screen edge retires on first move
        do_clear();
        aim(635, 100, 8'h7F, 8'h00);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        tick();
        chk("edge retire", int'(bullet_active[0]), 0);
        chk("edge x held", int'(bullet_x[9:0]), 635);

        // async reset mid-flight
        do_clear();
        aim(300, 250, 8'h7F, 8'h00);
        fif.shoot = 1'b1; tick();
        #2 Reset_n = 1'b0;
        #1;
        chk("async ack", int'(fif.fire_ack), 0);
        chk("async active", int'(bullet_active), 0);
        chk("async hit", int'(hit), 0);
        #1 Reset_n = 1'b1;
        tick(); fif.shoot = 1'b0; tick();

        // clear zeroes cooldown so an immediate edge spawns in slot0
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        tick(2);
        do_clear();
        chk("clear active", int'(bullet_active), 0);
        fif.shoot = 1'b1; tick(); fif.shoot = 1'b0;
        chk("post clear ack", int'(fif.fire_ack), 1);
        chk("post clear slot0", int'(bullet_active), 1);

        // random play
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) fif.shoot = ~fif.shoot;
            if ($urandom_range(0, 7) == 0)
                aim($urandom_range(0, 639), $urandom_range(0, 479), 8'($urandom), 8'($urandom));
            for (int i = 0; i < N; i++) begin
                wall_x[i] = ($urandom_range(0, 15) == 0);
                wall_y[i] = ($urandom_range(0, 15) == 0);
            end
            if ($urandom_range(0, 49) == 0) begin
                enemy_x = 10'($urandom_range(0, 700));
                enemy_y = 10'($urandom_range(0, 520));
                enemy_s = 10'($urandom_range(0, 40));
            end
            clear = ($urandom_range(0, 299) == 0);
            tick();
        end
        clear = 1'b0;
        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
